boxhead_export_bank: RTL and testbench

Parametrised, frame-synchronous export register bank between the Nios II Avalon-MM fabric and the game-rendering logic. Software writes NUM_CH shadow channels at any time, then requests a commit; all channels transfer atomically to the export outputs on the next frame-sync rising edge. This gives tear-free game state to the VGA/sprite pipeline. It generalises the single 32-bit export word to N channels of configurable width with double buffering, a commit handshake and a frame counter.

---
 rtl/boxhead_export_bank_if.sv | 22 ++
 rtl/boxhead_export_bank.sv | 98 +++++++++
 tb/tb_boxhead_export_bank.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boxhead_export_bank_if.sv
// Avalon-MM slave bus bundle for boxhead_export_bank.
// Fixed 32-bit data path, word addressed, read latency 1, no waitrequest.
interface boxhead_export_bank_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/boxhead_export_bank.sv
// Frame-synchronous double-buffered export bank: shadows commit atomically on a frame_sync rising edge.
// Optional irq output enabled by defining BOXHEAD_EXPORT_IRQ_EN.
module boxhead_export_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  boxhead_export_bank_if.slave     avs,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] export_data,
  output logic                     export_update
`ifdef BOXHEAD_EXPORT_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int CTRL_ADDR   = NUM_CH;
  localparam int STATUS_ADDR = NUM_CH + 1;
  localparam int FCNT_ADDR   = NUM_CH + 2;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] shadow    [NUM_CH];
  logic [DATA_W-1:0] shadow_wr [NUM_CH];
  logic              frame_sync_q;
  logic              irq_flag;
  logic [31:0]       frame_cnt;
  logic [31:0]       addr;
  logic [31:0]       be_mask;
  logic [31:0]       rd_mux;
  logic              apply;
  logic              wr_ctrl;
  logic              wr_status;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rd_mux    = '0;
    addr      = 32'(avs.avs_address);
    be_mask   = {{8{avs.avs_byteenable[3]}}, {8{avs.avs_byteenable[2]}},
                 {8{avs.avs_byteenable[1]}}, {8{avs.avs_byteenable[0]}}};
    wr_ctrl   = avs.avs_write && (addr == CTRL_ADDR);
    wr_status = avs.avs_write && (addr == STATUS_ADDR);
    apply     = frame_sync && !frame_sync_q && (state == ARMED);
    for (int i = 0; i < NUM_CH; i++) begin
      // Merge enabled byte lanes into the zero-extended shadow, then keep only DATA_W bits.
      shadow_wr[i] = DATA_W'((32'(shadow[i]) & ~be_mask) | (avs.avs_writedata & be_mask));
      if (addr == i) rd_mux = 32'(shadow[i]);
    end
    if (addr == STATUS_ADDR) rd_mux = {30'd0, irq_flag, state == ARMED};
    if (addr == FCNT_ADDR)   rd_mux = frame_cnt;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      // NOTE: the shadow array is a bank of flops, not RAM, so it is cleared with the rest of the state.
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      state            <= IDLE;
      frame_sync_q     <= 1'b0;
      irq_flag         <= 1'b0;
      frame_cnt        <= '0;
      export_data      <= '0;
      export_update    <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      // NOTE: non-blocking everywhere, so export_data captures the pre-write shadow on a colliding write.
      frame_sync_q  <= frame_sync;
      export_update <= apply;

      if (apply) begin
        for (int i = 0; i < NUM_CH; i++) export_data[i*DATA_W +: DATA_W] <= shadow[i];
        frame_cnt <= frame_cnt + 32'd1;
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (avs.avs_write && (addr == i)) shadow[i] <= shadow_wr[i];
      end

      // ABORT beats COMMIT; a COMMIT landing on the apply edge re-arms for the next frame.
      if (wr_ctrl && avs.avs_writedata[1])      state <= IDLE;
      else if (wr_ctrl && avs.avs_writedata[0]) state <= ARMED;
      else if (apply)                           state <= IDLE;

      if (apply)                                   irq_flag <= 1'b1;
      else if (wr_status && avs.avs_writedata[1])  irq_flag <= 1'b0;

      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

`ifdef BOXHEAD_EXPORT_IRQ_EN
  assign irq = irq_flag;
`endif

endmodule

// File: tb/tb_boxhead_export_bank.sv
// Bench for boxhead_export_bank: directed literal checks plus randomized traffic against a behavioural model.
// A second 12-bit instance covers channel-width truncation.
module tb_boxhead_export_bank;

  localparam int CTRL_A = 4;
  localparam int STAT_A = 5;
  localparam int FCNT_A = 6;

  logic         clk;
  logic         rst;
  logic         fs;
  logic         fs12;
  logic [127:0] exp_d;
  logic         upd;
  logic [47:0]  exp12;
  logic         upd12;
`ifdef BOXHEAD_EXPORT_IRQ_EN
  logic         irq;
  logic         irq12;
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  boxhead_export_bank_if #(.ADDR_W(5)) bus ();
  boxhead_export_bank_if #(.ADDR_W(5)) bus12 ();

  boxhead_export_bank #(.NUM_CH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs           (bus),
    .frame_sync    (fs),
    .export_data   (exp_d),
    .export_update (upd)
`ifdef BOXHEAD_EXPORT_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  boxhead_export_bank #(.NUM_CH(4), .DATA_W(12), .ADDR_W(5)) dut12 (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs           (bus12),
    .frame_sync    (fs12),
    .export_data   (exp12),
    .export_update (upd12)
`ifdef BOXHEAD_EXPORT_IRQ_EN
    ,
    .irq           (irq12)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model of the main instance: plain registers updated by the register-map rules.
  logic [31:0]  m_sh [4];
  logic [127:0] m_exp;
  logic [31:0]  m_cnt;
  logic [31:0]  m_rd;
  bit           m_pend, m_flag, m_upd, m_fsq, m_ap;
  int           m_a;

  function automatic logic [31:0] m_read(input int a);
    if (a < 4)       return m_sh[a];
    if (a == STAT_A) return {30'd0, m_flag, m_pend};
    if (a == FCNT_A) return m_cnt;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_sh[i] = 32'd0;
      m_exp = '0; m_cnt = 0; m_rd = 0;
      m_pend = 0; m_flag = 0; m_upd = 0; m_fsq = 0;
    end else begin
      m_a  = int'(bus.avs_address);
      m_ap = fs && !m_fsq && m_pend;
      if (bus.avs_read) m_rd = m_read(m_a);
      if (m_ap) begin
        for (int i = 0; i < 4; i++) m_exp[i*32 +: 32] = m_sh[i];
        m_cnt = m_cnt + 1;
      end
      m_upd = m_ap;
      if (bus.avs_write) begin
        if (m_a < 4)
          for (int b = 0; b < 4; b++)
            if (bus.avs_byteenable[b]) m_sh[m_a][b*8 +: 8] = bus.avs_writedata[b*8 +: 8];
        if (m_a == STAT_A && bus.avs_writedata[1]) m_flag = 0;
      end
      if (m_ap) m_flag = 1;
      if (bus.avs_write && m_a == CTRL_A && bus.avs_writedata[1])      m_pend = 0;
      else if (bus.avs_write && m_a == CTRL_A && bus.avs_writedata[0]) m_pend = 1;
      else if (m_ap)                                                   m_pend = 0;
      m_fsq = fs;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("export_data", exp_d, m_exp);
      check("export_update", upd, m_upd);
      check("readdata", bus.avs_readdata, m_rd);
`ifdef BOXHEAD_EXPORT_IRQ_EN
      check("irq", irq, m_flag);
`endif
    end
  end

  task automatic cyc(input bit w, input int a, input logic [31:0] d, input logic [3:0] be,
                     input bit r, input bit f);
    bus.avs_write      = w;
    bus.avs_address    = 5'(a);
    bus.avs_writedata  = d;
    bus.avs_byteenable = be;
    bus.avs_read       = r;
    fs                 = f;
    @(negedge clk);
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    cyc(0, a, 32'd0, 4'h0, 1, 0);
    v = bus.avs_readdata;
  endtask

  task automatic cyc12(input bit w, input int a, input logic [31:0] d, input logic [3:0] be,
                       input bit r, input bit f);
    bus12.avs_write      = w;
    bus12.avs_address    = 5'(a);
    bus12.avs_writedata  = d;
    bus12.avs_byteenable = be;
    bus12.avs_read       = r;
    fs12                 = f;
    @(negedge clk);
  endtask

  task automatic rd12(input int a, output logic [31:0] v);
    cyc12(0, a, 32'd0, 4'h0, 1, 0);
    v = bus12.avs_readdata;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear immediately.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("reset_export", exp_d, 128'd0);
    check("reset_update", upd, 1'b0);
    check("reset_readdata", bus.avs_readdata, 32'd0);
`ifdef BOXHEAD_EXPORT_IRQ_EN
    check("reset_irq", irq, 1'b0);
`endif
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v, d;
    logic [3:0]  be;
    int          r, a;
    bit          f;

    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc12(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    check("rst_export_data", exp_d, 128'd0);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    rd(STAT_A, v); check("rst_status", v, 32'd0);
    rd(FCNT_A, v); check("rst_frame_cnt", v, 32'd0);

    // Basic commit: the frame edge arrives the cycle after COMMIT.
    for (int i = 0; i < 4; i++) cyc(1, i, 32'h11111111 * (i + 1), 4'hF, 0, 0);
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("apply_update", upd, 1'b1);
    check("apply_export", exp_d, 128'h44444444_33333333_22222222_11111111);
    cyc(0, 0, 0, 0, 0, 1);
    check("held_sync_no_update", upd, 1'b0);
    rd(FCNT_A, v); check("frame_cnt_1", v, 32'd1);
    rd(STAT_A, v); check("status_after_apply", v, 32'd2);
    cyc(1, STAT_A, 32'd2, 4'hF, 0, 0);
    rd(STAT_A, v); check("status_w1c", v, 32'd0);

    // Partial byte write without COMMIT; frame edge does nothing.
    cyc(1, 1, 32'd0, 4'hF, 0, 0);
    cyc(1, 1, 32'hAABBCCDD, 4'b0011, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("no_commit_update", upd, 1'b0);
    check("no_commit_export", exp_d, 128'h44444444_33333333_22222222_11111111);
    rd(1, v); check("byteenable_readback", v, 32'h0000CCDD);

    // COMMIT on the apply edge re-arms; next edge applies again.
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 1);
    check("commit_on_apply_update", upd, 1'b1);
    rd(STAT_A, v); check("rearmed_status", v, 32'd3);
    cyc(0, 0, 0, 0, 0, 1);
    check("reapply_update", upd, 1'b1);
    check("reapply_export", exp_d, 128'h44444444_33333333_0000CCDD_11111111);
    rd(FCNT_A, v); check("frame_cnt_3", v, 32'd3);

    // Shadow write on the apply edge: export takes the old value, no re-arm.
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc(1, 0, 32'hDEADBEEF, 4'hF, 0, 1);
    check("collide_export", exp_d, 128'h44444444_33333333_0000CCDD_11111111);
    rd(0, v); check("collide_shadow", v, 32'hDEADBEEF);
    rd(STAT_A, v); check("collide_status", v, 32'd2);

    // COMMIT+ABORT together, ABORT on apply edge, COMMIT then ABORT.
    cyc(1, CTRL_A, 32'd3, 4'hF, 0, 0);
    rd(STAT_A, v); check("commit_abort_status", v, 32'd2);
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc(1, CTRL_A, 32'd2, 4'hF, 0, 1);
    check("abort_on_apply_update", upd, 1'b1);
    rd(STAT_A, v); check("abort_on_apply_status", v, 32'd2);
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc(1, CTRL_A, 32'd2, 4'hF, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("aborted_update", upd, 1'b0);
    rd(FCNT_A, v); check("frame_cnt_5", v, 32'd5);
    rd(7, v); check("unmapped_read", v, 32'd0);

`ifdef BOXHEAD_EXPORT_IRQ_EN
    check("irq_set", irq, 1'b1);
    cyc(1, STAT_A, 32'd2, 4'hF, 0, 0);
    check("irq_cleared", irq, 1'b0);
`endif

    // Reset while a commit is pending.
    cyc(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    pulse_reset();
    rd(STAT_A, v); check("post_reset_status", v, 32'd0);
    rd(FCNT_A, v); check("post_reset_cnt", v, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    check("lost_commit_update", upd, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);

    // Narrow-channel instance.
    cyc12(1, 0, 32'hFFFFFFFF, 4'hF, 0, 0);
    rd12(0, v); check("w12_readback", v, 32'h00000FFF);
    cyc12(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc12(1, CTRL_A, 32'd2, 4'hF, 0, 0);
    cyc12(0, 0, 0, 0, 0, 1);
    check("w12_abort_update", upd12, 1'b0);
    check("w12_abort_export", exp12, 48'd0);
    rd12(FCNT_A, v); check("w12_frame_cnt", v, 32'd0);
    cyc12(1, CTRL_A, 32'd1, 4'hF, 0, 0);
    cyc12(0, 0, 0, 0, 0, 1);
    check("w12_apply_update", upd12, 1'b1);
    check("w12_apply_export", exp12, 48'h000000000FFF);
    cyc12(1, 0, 32'hABCDEF12, 4'b0011, 0, 0);
    rd12(0, v); check("w12_partial", v, 32'h00000F12);

    // Randomized traffic, checked every cycle by the compare process.
    f = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) f = !f;
      if (r < 18) begin
        cyc(1, $urandom_range(0, 3), d, be, 0, f);
      end else if (r < 28) begin
        cyc(1, CTRL_A, (d & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)), be, 0, f);
      end else if (r < 33) begin
        cyc(1, STAT_A, d, be, 0, f);
      end else if (r < 36) begin
        cyc(1, $urandom_range(6, 31), d, be, 0, f);
      end else if (r < 76) begin
        a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        cyc(0, a, d, be, 1, f);
      end else begin
        cyc(0, 0, d, be, 0, f);
      end
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
